// File: rtl/lut_layer_sequencer.sv
// rtl/lut_layer_sequencer.sv - time-multiplexed sparse LUT layer evaluator
//
// Captures one input vector, evaluates one FANIN-input LUT neuron per cycle
// through a shared datapath, then presents the packed layer result.
// Truth tables and connectivity are written at runtime over cfg_*.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input vector handshake, s_data = IN_W-bit vector
//   m_valid/m_ready   result handshake, m_data bit n = neuron n
//   cfg_we            single-cycle config write strobe
//   cfg_sel           0 = truth-table bit, 1 = connectivity index
//   cfg_neuron        target neuron
//   cfg_addr          table: LUT address; conn: fan-in slot (low bits)
//   cfg_data          table: bit 0 = entry; conn: input index
//   cfg_err           one-cycle pulse after a rejected config write
//   busy              high while evaluating or holding a result
module lut_layer_sequencer #(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 6,
  parameter int IDX_W     = $clog2(IN_W),
  parameter int NID_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N_NEURONS-1:0] m_data,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [NID_W-1:0]     cfg_neuron,
  input  logic [FANIN-1:0]     cfg_addr,
  input  logic [IDX_W-1:0]     cfg_data,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int DEPTH  = 2 ** FANIN;
  localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  state_t               state, state_nx;
  logic [NID_W-1:0]     cnt;
  logic [IN_W-1:0]      in_reg;
  logic [N_NEURONS-1:0] res, res_nx;
  logic [FANIN-1:0]     addr;
  logic                 lut_bit;
  logic                 last;
  logic                 accept;
  logic                 cfg_ok;
  logic [SLOT_W-1:0]    slot;

  // Configuration storage is deliberately outside reset so a pipeline
  // flush never loses the programmed network.
  logic [DEPTH-1:0]     tbl  [N_NEURONS];
  logic [IDX_W-1:0]     conn [N_NEURONS][FANIN];

  assign slot   = cfg_addr[SLOT_W-1:0];
  assign last   = (cnt == NID_W'(N_NEURONS - 1));
  assign accept = s_valid && s_ready;

  // Gather the current neuron's fan-in bits into a LUT address.
  always_comb begin
    addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      addr[k] = in_reg[conn[cnt][k]];
    end
    lut_bit     = tbl[cnt][addr];
    res_nx      = res;
    res_nx[cnt] = lut_bit;
  end

  // A write is only legal in IDLE when no vector is being taken that cycle,
  // so an evaluation never sees a half-updated network.
  always_comb begin
    cfg_ok = (state == IDLE) && !accept && (32'(cfg_neuron) < N_NEURONS);
    if (cfg_sel) begin
      cfg_ok = cfg_ok && (32'(slot) < FANIN) && (32'(cfg_data) < IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (last) state_nx = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      m_data  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (accept) begin
        in_reg <= s_data;
        cnt    <= '0;
      end
      if (state == EVAL) begin
        res <= res_nx;
        cnt <= cnt + 1'b1;
        // The final neuron's bit goes straight into the result register.
        if (last) begin
          m_data <= res_nx;
          cnt    <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ok && !rst) begin
      if (!cfg_sel) begin
        tbl[cfg_neuron][cfg_addr] <= cfg_data[0];
      end else begin
        conn[cfg_neuron][slot] <= cfg_data;
      end
    end
  end

endmodule
